// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared widths, requester identifiers and payload types for the register-file
// write-port arbiter and its scoreboard.
//   N_REQ    : number of write-back requesters (ALU, LOAD, LINK)
//   ADDR_W   : register address width
//   DATA_W   : register data width
//   CNT_W    : width of each per-register pending-write counter
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned N_REGS = 1 << ADDR_W;

  typedef enum logic [ID_W-1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_LINK = 2'd2
  } req_id_t;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam cnt_t CNT_MAX = '1;

  // One register-file write as it leaves the output stage
  typedef struct packed {
    addr_t   addr;
    data_t   data;
    req_id_t id;
  } wr_t;

  // Requester that follows `id` in round-robin order
  function automatic req_id_t next_id(req_id_t id);
    if (id == REQ_LINK) begin
      return REQ_ALU;
    end
    return req_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Bundles the write-back request handshake, the decode reservation/stall
// signals and the register-file write port.
//   req_valid/req_ready/req_addr/req_data : write-back requesters
//   rsv_valid/rsv_addr/rsv_ready          : destination reservation from decode
//   RA/RB, stall_a/stall_b                : hazard query from decode
//   RW/en/busW/grant_id                   : register-file write port
// slave  : the arbiter side
// master : the pipeline side (requesters, decode, register file)
// -----------------------------------------------------------------------------
interface regfile_wr_arbiter_if;
  import regfile_pkg::*;

  logic  [N_REQ-1:0] req_valid;
  logic  [N_REQ-1:0] req_ready;
  addr_t [N_REQ-1:0] req_addr;
  data_t [N_REQ-1:0] req_data;

  logic  rsv_valid;
  addr_t rsv_addr;
  logic  rsv_ready;

  addr_t RA;
  addr_t RB;
  logic  stall_a;
  logic  stall_b;

  addr_t           RW;
  logic            en;
  data_t           busW;
  logic [ID_W-1:0] grant_id;

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr, RA, RB,
    output req_ready, rsv_ready, stall_a, stall_b, RW, en, busW, grant_id
  );

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr, RA, RB,
    input  req_ready, rsv_ready, stall_a, stall_b, RW, en, busW, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// N_REQ-way round-robin arbiter. The highest-priority requester is the one
// after the last accepted grant; the pointer only moves on i_accept.
//   clk, rst  : clock, synchronous active-high reset
//   i_valid   : request vector
//   i_accept  : the current grant was taken (transfer happened)
//   o_grant   : one-hot grant, only ever for a valid requester
//   o_idx     : encoded index of o_grant (REQ_ALU when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_accept,
  output logic [N_REQ-1:0] o_grant,
  output req_id_t          o_idx
);

  // Requester with highest priority this cycle
  req_id_t r_ptr;

  // Pointer register: reset gives requester 0 top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= REQ_ALU;
    end else if (i_accept) begin
      r_ptr <= next_id(o_idx);
    end
  end

  // Scan requesters starting at the pointer; first valid one wins
  always_comb begin
    req_id_t w_cand;
    logic    w_found;
    o_grant = '0;
    o_idx   = REQ_ALU;
    w_found = 1'b0;
    w_cand  = r_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && i_valid[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
      w_cand = next_id(w_cand);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the register-file write port between the ALU, LOAD and LINK
// write-back requesters and tracks pending writes per register so decode can
// stall on read-after-write hazards.
//   clk  : system clock (shared with the register file)
//   rst  : synchronous active-high reset
//   bus  : regfile_wr_arbiter_if.slave
//          req_*     round-robin arbitrated write-back requests
//          rsv_*     destination reservations from decode
//          RA/RB     decode read addresses -> stall_a/stall_b
//          RW/en/busW/grant_id registered register-file write port
// A transfer in cycle N produces the write in cycle N+1. Writes to register 0
// are accepted but never enabled. Counters move at the transfer edge.
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  logic [N_REQ-1:0]  w_grant;
  logic [N_REQ-1:0]  w_ready;
  req_id_t           w_idx;
  logic              w_xfer;
  addr_t             w_xaddr;
  data_t             w_xdata;
  logic              w_rsv_ready;
  logic              w_rsv_fire;
  logic [N_REGS-1:0] w_inc;
  logic [N_REGS-1:0] w_dec;
  logic              w_underflow;

  cnt_t r_cnt [N_REGS];
  wr_t  r_wr;
  logic r_en;

  rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.req_valid),
    .i_accept (w_xfer),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  // Handshake: no grants while in reset, so nothing transfers in that cycle
  always_comb begin
    w_ready = rst ? '0 : w_grant;
    w_xfer  = |w_ready;
    w_xaddr = bus.req_addr[w_idx];
    w_xdata = bus.req_data[w_idx];
  end

  assign bus.req_ready = w_ready;

  // Reservation acceptance; register 0 is never tracked so always accepted
  always_comb begin
    w_rsv_ready = (bus.rsv_addr == '0) || (r_cnt[bus.rsv_addr] != CNT_MAX);
    w_rsv_fire  = bus.rsv_valid && w_rsv_ready && (bus.rsv_addr != '0);
  end

  assign bus.rsv_ready = w_rsv_ready;

  // Per-register increment/decrement requests for this cycle
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_rsv_fire) begin
      w_inc[bus.rsv_addr] = 1'b1;
    end
    if (w_xfer) begin
      w_dec[w_xaddr] = 1'b1;
    end
    w_inc[0] = 1'b0;
    w_dec[0] = 1'b0;
  end

  // A lone decrement of an empty counter means a write nobody reserved
  always_comb begin
    w_underflow = 1'b0;
    if (w_xfer && (w_xaddr != '0) && (r_cnt[w_xaddr] == '0) && !w_inc[w_xaddr]) begin
      w_underflow = 1'b1;
    end
  end

  // Pending-write counters; a same-cycle reserve and transfer cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < N_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < N_REGS; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          if (r_cnt[r] != CNT_MAX) begin
            r_cnt[r] <= r_cnt[r] + cnt_t'(1);
          end
        end else if (w_dec[r] && !w_inc[r]) begin
          if (r_cnt[r] != '0) begin
            r_cnt[r] <= r_cnt[r] - cnt_t'(1);
          end
        end
      end
    end
  end

  // Hazard query straight from counter state; register 0 never stalls
  always_comb begin
    bus.stall_a = (bus.RA != '0) && (r_cnt[bus.RA] != '0);
    bus.stall_b = (bus.RB != '0) && (r_cnt[bus.RB] != '0);
  end

  // Output stage: one-cycle write pulse after each transfer to a non-zero reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_en <= 1'b0;
    end else begin
      r_en <= w_xfer && (w_xaddr != '0);
      if (w_xfer) begin
        r_wr <= '{addr: w_xaddr, data: w_xdata, id: w_idx};
      end
    end
  end

  assign bus.RW       = r_wr.addr;
  assign bus.busW     = r_wr.data;
  assign bus.grant_id = r_wr.id;
  assign bus.en       = r_en;

  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !w_underflow);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus state (what the requesters / decode drive next cycle)
  bit          t_rst;
  bit   [2:0]  pv;
  logic [4:0]  pa [3];
  logic [31:0] pd [3];
  bit          rv;
  logic [4:0]  ra;
  logic [4:0]  ta;
  logic [4:0]  tb;

  // Reference model: pending counts, last granted requester, expected port
  int          m_cnt [32];
  int          m_last;
  logic [4:0]  e_rw;
  logic [31:0] e_bus;
  logic [1:0]  e_gid;
  logic        e_en;

  // Values sampled from the DUT in the latest cycle
  logic [2:0]  s_ready;
  logic        s_rsv;
  logic        s_sa;
  logic        s_sb;
  logic [4:0]  s_rw;
  logic [31:0] s_bus;
  logic [1:0]  s_gid;
  logic        s_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, compare with model, advance model
  task automatic step();
    int       g;
    logic [2:0] eready;
    bit       ersv;
    bit       esa;
    bit       esb;
    @(posedge clk);
    #1;
    rst = t_rst;
    bus.req_valid = pv;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[i] = pa[i];
      bus.req_data[i] = pd[i];
    end
    bus.rsv_valid = rv;
    bus.rsv_addr  = ra;
    bus.RA        = ta;
    bus.RB        = tb;
    #4;
    g = -1;
    if (!t_rst) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (g < 0 && pv[i]) g = i;
      end
    end
    eready = (g < 0) ? 3'b000 : 3'(1 << g);
    ersv = (ra == 0) || (m_cnt[ra] != 3);
    esa  = (ta != 0) && (m_cnt[ta] != 0);
    esb  = (tb != 0) && (m_cnt[tb] != 0);

    s_ready = bus.req_ready;
    s_rsv   = bus.rsv_ready;
    s_sa    = bus.stall_a;
    s_sb    = bus.stall_b;
    s_rw    = bus.RW;
    s_bus   = bus.busW;
    s_gid   = bus.grant_id;
    s_en    = bus.en;

    check("req_ready", 32'(s_ready), 32'(eready));
    check("rsv_ready", 32'(s_rsv), 32'(ersv));
    check("stall_a", 32'(s_sa), 32'(esa));
    check("stall_b", 32'(s_sb), 32'(esb));
    check("en", 32'(s_en), 32'(e_en));
    if (e_en) begin
      check("RW", 32'(s_rw), 32'(e_rw));
      check("busW", s_bus, e_bus);
      check("grant_id", 32'(s_gid), 32'(e_gid));
    end

    if (t_rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_last = 2;
      e_rw = '0; e_bus = '0; e_gid = '0; e_en = 1'b0;
      pv = '0;
    end else begin
      if (rv && ersv && ra != 0) m_cnt[ra]++;
      if (g >= 0) begin
        e_rw  = pa[g];
        e_bus = pd[g];
        e_gid = 2'(g);
        e_en  = (pa[g] != 0);
        m_last = g;
        if (pa[g] != 0 && m_cnt[pa[g]] > 0) m_cnt[pa[g]]--;
        pv[g] = 1'b0;
      end else begin
        e_en = 1'b0;
      end
    end
    rv = 1'b0;
  endtask

  task automatic reserve(input logic [4:0] r);
    rv = 1'b1;
    ra = r;
    step();
  endtask

  initial begin
    int avail;
    int r;
    t_rst = 1'b1; pv = '0; rv = 1'b0; ra = '0; ta = '0; tb = '0;
    for (int i = 0; i < 3; i++) begin pa[i] = '0; pd[i] = '0; end
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_last = 2;
    e_rw = '0; e_bus = '0; e_gid = '0; e_en = 1'b0;
    rst = 1'b1;
    bus.req_valid = '0; bus.rsv_valid = 1'b0; bus.rsv_addr = '0;
    bus.RA = '0; bus.RB = '0;
    for (int i = 0; i < 3; i++) begin bus.req_addr[i] = '0; bus.req_data[i] = '0; end
    @(posedge clk);

    // Reset held two cycles with every requester valid
    ta = 5'd7; tb = 5'd3;
    for (int c = 0; c < 2; c++) begin
      t_rst = 1'b1;
      pv = 3'b111;
      for (int i = 0; i < 3; i++) begin pa[i] = 5'(i + 1); pd[i] = $urandom; end
      step();
      check("reset ready", 32'(s_ready), 32'h0);
      check("reset en", 32'(s_en), 32'h0);
      check("reset RW", 32'(s_rw), 32'h0);
      check("reset busW", s_bus, 32'h0);
      check("reset stall_a", 32'(s_sa), 32'h0);
      check("reset stall_b", 32'(s_sb), 32'h0);
    end
    t_rst = 1'b0;
    ta = '0; tb = '0;

    // Round robin with all three requesters continuously valid
    for (int k = 0; k < 9; k++) reserve(5'(k % 3 + 1));
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i]) begin pv[i] = 1'b1; pa[i] = 5'(i + 1); pd[i] = $urandom; end
      end
      step();
      check("rr grant", 32'(s_ready), 32'(3'b001 << (k % 3)));
      if (k > 0) check("rr en", 32'(s_en), 32'h1);
    end
    for (int k = 0; k < 3; k++) step();

    // Single ALU write to r5
    reserve(5'd5);
    pv = 3'b001; pa[0] = 5'd5; pd[0] = 32'hDEADBEEF;
    step();
    check("single ready", 32'(s_ready), 32'h1);
    step();
    check("single RW", 32'(s_rw), 32'd5);
    check("single en", 32'(s_en), 32'h1);
    check("single busW", s_bus, 32'hDEADBEEF);
    check("single grant_id", 32'(s_gid), 32'h0);
    step();
    check("single en drop", 32'(s_en), 32'h0);

    // LOAD write to register 0
    pv = 3'b010; pa[1] = 5'd0; pd[1] = 32'h1234; ta = 5'd0;
    step();
    check("r0 ready", 32'(s_ready), 32'h2);
    step();
    check("r0 en", 32'(s_en), 32'h0);
    check("r0 stall_a", 32'(s_sa), 32'h0);

    // Saturate r7, then drain it with three transfers
    ta = 5'd7;
    for (int k = 0; k < 4; k++) begin
      reserve(5'd7);
      check("r7 rsv_ready", 32'(s_rsv), (k < 3) ? 32'h1 : 32'h0);
    end
    step();
    check("r7 stall sat", 32'(s_sa), 32'h1);
    for (int k = 0; k < 3; k++) begin
      pv = 3'b001; pa[0] = 5'd7; pd[0] = $urandom;
      step();
      check("r7 xfer ready", 32'(s_ready), 32'h1);
      check("r7 stall drain", 32'(s_sa), 32'h1);
    end
    step();
    check("r7 stall clear", 32'(s_sa), 32'h0);

    // Reserve and transfer r9 in the same cycle
    reserve(5'd9);
    rv = 1'b1; ra = 5'd9; pv = 3'b001; pa[0] = 5'd9; pd[0] = $urandom; tb = 5'd9;
    step();
    step();
    check("r9 stall_b", 32'(s_sb), 32'h1);

    // Reset while a transfer is pending
    reserve(5'd1);
    pv = 3'b001; pa[0] = 5'd1; pd[0] = $urandom; t_rst = 1'b1;
    step();
    t_rst = 1'b0; ta = 5'd1; tb = 5'd9;
    step();
    check("midrst en", 32'(s_en), 32'h0);
    check("midrst stall_a", 32'(s_sa), 32'h0);
    check("midrst stall_b", 32'(s_sb), 32'h0);

    // Randomized traffic; requesters only target registers with spare reservations
    for (int c = 0; c < 3000; c++) begin
      t_rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          avail = 1;
          if (r != 0) begin
            avail = m_cnt[r];
            for (int j = 0; j < 3; j++) if (pv[j] && pa[j] == 5'(r)) avail--;
          end
          if (avail > 0) begin
            pv[i] = 1'b1; pa[i] = 5'(r); pd[i] = $urandom;
          end
        end
      end
      rv = ($urandom_range(0, 1) == 1);
      ra = 5'($urandom_range(0, 7));
      ta = 5'($urandom_range(0, 7));
      tb = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
